// File: rtl/cpu_pkg.sv
// Shared memory-map constants and responder FSM encoding for the CPU memory port.
package cpu_pkg;

    localparam logic [15:0] IO_BASE_ADDR = 16'hFF00;

    localparam int IO_LED  = 0;
    localparam int IO_SW   = 1;
    localparam int IO_TICK = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM with a 1-cycle read and write-first behaviour.
// It has no reset, so its contents survive a reset of the surrounding logic.
module bram_sp #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
                rdata_q     <= wdata_i;
            end else begin
                rdata_q     <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Serves CPU memory requests from block RAM or the LED/switch/tick I/O window.
// A request accepted in IDLE is answered by a one-cycle mem_ready two edges later; inputs are ignored outside IDLE.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter int               RAM_ADDR_BITS = 12,
    parameter logic [WIDTH-1:0] IO_BASE       = IO_BASE_ADDR,
    parameter string            INIT_FILE     = "",
    parameter int               SW_BITS       = 8,
    parameter int               LED_BITS      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_req,
    input  logic                mem_write,
    input  logic [WIDTH-1:0]    mem_address,
    input  logic [WIDTH-1:0]    data_to_mem_store,
    output logic [WIDTH-1:0]    data_from_mem,
    output logic                mem_ready,
    input  logic [SW_BITS-1:0]  switches_in,
    output logic [LED_BITS-1:0] leds_out
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic [LED_BITS-1:0] leds_q, leds_d;
    logic [WIDTH-1:0]    tick_q, tick_d;
    logic [SW_BITS-1:0]  sw_meta_q, sw_sync_q;

    logic                     is_ram, is_io, is_led, is_sw, is_tick;
    logic [WIDTH-1:0]         io_off;
    logic                     accept, busy_wr, busy_rd;
    logic                     ram_en, ram_we;
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic [WIDTH-1:0]         ram_rdata;
    logic [WIDTH-1:0]         load_val;

    // Decode always works from the latched address; the live bus may change after IDLE.
    assign is_ram  = (addr_q >> RAM_ADDR_BITS) == '0;
    assign is_io   = addr_q >= IO_BASE;
    assign io_off  = addr_q - IO_BASE;
    assign is_led  = is_io && (io_off == WIDTH'(IO_LED));
    assign is_sw   = is_io && (io_off == WIDTH'(IO_SW));
    assign is_tick = is_io && (io_off == WIDTH'(IO_TICK));

    assign accept  = (state_q == IDLE) && mem_req;
    assign busy_wr = (state_q == BUSY) && write_q;
    assign busy_rd = (state_q == BUSY) && !write_q;

    // The read is launched from the live address so RAM data is ready by the BUSY edge.
    assign ram_addr = (state_q == IDLE) ? mem_address[RAM_ADDR_BITS-1:0]
                                        : addr_q[RAM_ADDR_BITS-1:0];
    assign ram_we   = busy_wr && is_ram;
    assign ram_en   = accept || ram_we;

    bram_sp #(
        .DATA_W    (WIDTH),
        .ADDR_W    (RAM_ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_req) state_d = BUSY;
            BUSY:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == RESP);
    end

    always_comb begin
        load_val = '0;
        if (is_ram) begin
            load_val = ram_rdata;
        end else if (is_led) begin
            load_val = WIDTH'(leds_q);
        end else if (is_sw) begin
            load_val = WIDTH'(sw_sync_q);
        end else if (is_tick) begin
            load_val = tick_q;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        if (accept) begin
            addr_d  = mem_address;
            wdata_d = data_to_mem_store;
            write_d = mem_write;
        end

        rdata_d = rdata_q;
        if (busy_rd) begin
            rdata_d = load_val;
        end

        leds_d = leds_q;
        if (busy_wr && is_led) begin
            leds_d = wdata_q[LED_BITS-1:0];
        end

        // A store to TICK overrides that cycle's increment.
        tick_d = tick_q + WIDTH'(1);
        if (busy_wr && is_tick) begin
            tick_d = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            leds_q    <= '0;
            tick_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            leds_q    <= leds_d;
            tick_q    <= tick_d;
            sw_meta_q <= switches_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign data_from_mem = rdata_q;
    assign leds_out      = leds_q;

endmodule
